multiphase_dds_sine: RTL
========================

Name: multiphase_dds_sine

Overview:
- Parametrised N-channel sine source for the modulating-wave path. It replaces the fixed 3-output triangle-address LUT sweep with a phase-accumulator (DDS) core.
- A single quarter-wave LUT is time-multiplexed across channels, with a per-channel phase offset and run-time frequency control.
- On each sample strobe, all channel outputs update coherently in one cycle. These outputs feed the downstream carrier comparators.

Parameters:
NCH, 3, number of output channels (1..16)
DW, 12, output sample width, signed two's complement
LUT_AW, 10, quarter-wave LUT address bits (depth 2^LUT_AW)
PHW, 24, phase accumulator width; must satisfy PHW >= LUT_AW+2
LUT_FILE, "sine_q.mem", binary init file for the quarter-wave LUT

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  sample strobe, one clk wide
ftw  in  PHW  frequency tuning word, sampled on accepted en
phase_off  in  NCH*PHW  per-channel phase offset; channel k occupies bits [k*PHW +: PHW]
out  out  NCH*DW  signed samples; channel k occupies bits [k*DW +: DW]
out_valid  out  1  one-cycle pulse when out is updated
busy  out  1  high from accepted en until out_valid
overrun  out  1  sticky; set when en arrives while busy

Behaviour:
- One clock; reset is synchronous and active-high on rst.
- Reset values:
  - acc=0, out=0 on all channels, out_valid=0, busy=0, overrun=0.
  - FSM state is IDLE; the channel counter is 0.
- LUT contents:
  - Entry i = round((2^(DW-1)-1)*sin(2*pi*(i+0.5)/(4*2^LUT_AW))), unsigned, DW-1 bits.
  - The half-sample offset makes quadrant mirroring exact.
  - For DW=12, LUT_AW=10: entry 0=2, entry 1023=2047.
- Accepted en means en=1 while in IDLE.
  - On that cycle: base <= acc, acc <= acc+ftw (mod 2^PHW), busy <= 1, FSM goes to RUN.
- FSM states:
  - IDLE -> RUN on accepted en.
  - RUN: issue channel k=0..NCH-1, one per cycle. After k=NCH-1, go to DRAIN.
  - DRAIN: 2 cycles to flush the pipeline, then commit. At commit: out_valid=1, busy=0, FSM goes to IDLE.
- Per-channel pipeline (3 stages):
  - S0: p = base + phase_off[k] (mod 2^PHW); q = p[PHW-1:PHW-2]; idx = p[PHW-3:PHW-2-LUT_AW]. If q[0]=1, idx = ~idx (mirror).
  - S1: registered LUT read mag = lut[idx].
  - S2: s = q[1] ? -mag : +mag, sign-extended to DW. The result is written into shadow register k.
  - No overflow is possible, since |mag| <= 2^(DW-1)-1.
- Commit: all shadow registers copy to out in the same cycle that out_valid=1, so out never shows a mix of old and new samples.
- Latency: accepted en at cycle 0 -> out_valid at cycle NCH+2.
  - Minimum en spacing without overrun is NCH+3 cycles.
- en while busy:
  - The strobe is ignored: acc is not advanced and ftw is not sampled.
  - overrun <= 1. overrun is cleared only by rst.
- en in the same cycle as the commit is also ignored and sets overrun, because busy=1 on that cycle.
- rst mid-operation:
  - Aborts immediately and applies the reset values.
  - The pending out_valid is suppressed. The next en behaves as the first after reset.
- ftw=0 holds the phase constant. Accumulator wrap is natural modulo 2^PHW.

Optional Feature:
- Macro: MODWAVE_AMP_EN
- Defined:
  - Adds port amp (in, DW bits, unsigned) and an extra pipeline stage S3.
  - amp_c = min(amp, 2^(DW-1)).
  - out_k = (s*amp_c) >>> (DW-1), using an arithmetic shift (floor).
  - amp is sampled on accepted en, alongside ftw.
  - Latency becomes NCH+3; minimum en spacing becomes NCH+4.
- Undefined: no amp port and no S3 stage; unity gain with the latency stated above.

Test Plan:
1. rst, then en with ftw=0 and all phase_off=0 -> out_valid at cycle 5 (NCH=3); all three channels = 2; busy high for cycles 0-4.
2. phase_off = {2^23, 2^22, 0} (ch2, ch1, ch0) with ftw=0 -> ch0=2, ch1=2047, ch2=-2. Then set ch0 offset to 3*2^22 -> ch0=-2047.
3. ftw=2^22, phase_off=0, six strobes spaced 8 cycles apart -> ch0 sequence 2, 2047, -2, -2047, 2, 2047 (wrap verified); overrun stays 0.
4. en, then a second en 2 cycles later -> the second strobe is ignored; the next ch0 value reflects a single ftw step; overrun=1 and remains 1 until rst.
5. rst asserted 2 cycles after en -> no out_valid; out=0. A fresh en then reproduces scenario 1 values exactly.
6. With MODWAVE_AMP_EN, phase_off={3*2^22, 2^22, 0}:
   - amp=1024 -> ch1=1023, ch2=-1024, ch0=1.
   - amp=4095 (clamped) -> outputs equal the unity-gain values.
   - out_valid arrives at cycle 6.

Source files
------------

// File: rtl/multiphase_dds_sine.sv
// multiphase_dds_sine: N-channel DDS sine source time-sharing one quarter-wave LUT, with coherent output commit.
// Optional MODWAVE_AMP_EN adds an amp port and an amplitude-scaling stage S3.
module multiphase_dds_sine #(
    parameter int NCH = 3,
    parameter int DW = 12,
    parameter int LUT_AW = 10,
    parameter int PHW = 24,
    parameter LUT_FILE = "sine_q.mem"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [PHW-1:0]       ftw,
    input  logic [NCH*PHW-1:0]   phase_off,
`ifdef MODWAVE_AMP_EN
    input  logic [DW-1:0]        amp,
`endif
    output logic [NCH*DW-1:0]    out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
`ifdef MODWAVE_AMP_EN
    localparam int DRAIN_N = 3;
`else
    localparam int DRAIN_N = 2;
`endif

    if (NCH < 1 || NCH > 16 || PHW < LUT_AW + 2 || $bits(LUT_FILE) == 0) begin : g_bad_cfg
        $error("multiphase_dds_sine: unsupported parameter set");
    end

    // LUT is built at elaboration with the same formula the init file holds, so no file is needed.
    function automatic int lut_entry(input int i);
        real x, t, s;
        x = 6.283185307179586 * (real'(i) + 0.5) / real'(4 * 2 ** LUT_AW);
        t = x;
        s = x;
        for (int n = 1; n < 12; n++) begin
            t = -t * x * x / real'((2 * n) * (2 * n + 1));
            s = s + t;
        end
        return $rtoi(real'(2 ** (DW - 1) - 1) * s + 0.5);
    endfunction

    logic [DW-2:0] lut [2**LUT_AW];
    for (genvar i = 0; i < 2 ** LUT_AW; i++) begin : g_lut
        localparam logic [DW-2:0] V = (DW-1)'(lut_entry(i));
        assign lut[i] = V;
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [CW-1:0]      k;
    logic [1:0]         dcnt;
    logic [PHW-1:0]     acc;
    logic [PHW-1:0]     base;
    logic [NCH*DW-1:0]  shadow;
`ifdef MODWAVE_AMP_EN
    logic [DW-1:0]      amp_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k <= '0;
            dcnt <= '0;
            acc <= '0;
            base <= '0;
            out <= '0;
            out_valid <= 1'b0;
            busy <= 1'b0;
            overrun <= 1'b0;
`ifdef MODWAVE_AMP_EN
            amp_q <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (en && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (en) begin
                    base <= acc;
                    acc <= acc + ftw;
                    busy <= 1'b1;
                    k <= '0;
                    state <= RUN;
`ifdef MODWAVE_AMP_EN
                    amp_q <= amp > DW'(2 ** (DW - 1)) ? DW'(2 ** (DW - 1)) : amp;
`endif
                end
                RUN: begin
                    k <= k + 1'b1;
                    if (k == CW'(NCH - 1)) begin
                        state <= DRAIN;
                        dcnt <= '0;
                    end
                end
                DRAIN: if (dcnt == 2'(DRAIN_N - 1)) begin
                    out <= shadow;
                    out_valid <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [PHW-1:0]       off;
    logic [LUT_AW+1:0]    top;
    logic [LUT_AW-1:0]    idx;
    logic                 v1;
    logic                 neg1;
    logic [CW-1:0]        k1;
    logic [DW-2:0]        mag;
    logic signed [DW-1:0] s;

    // Top two phase bits select the quadrant; odd quadrants read the LUT mirrored.
    assign off = phase_off[k*PHW +: PHW];
    assign top = (LUT_AW+2)'((base + off) >> (PHW - LUT_AW - 2));
    assign idx = top[LUT_AW] ? ~top[LUT_AW-1:0] : top[LUT_AW-1:0];
    assign s = neg1 ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

    always_ff @(posedge clk) begin
        v1 <= rst ? 1'b0 : state == RUN;
        k1 <= k;
        neg1 <= top[LUT_AW+1];
        mag <= lut[idx];
    end

`ifdef MODWAVE_AMP_EN
    logic                 v2;
    logic [CW-1:0]        k2;
    logic signed [DW-1:0] s2;
    logic signed [2*DW:0] prod;

    assign prod = s2 * $signed({1'b0, amp_q});

    always_ff @(posedge clk) begin
        v2 <= rst ? 1'b0 : v1;
        k2 <= k1;
        s2 <= s;
        if (v2) shadow[k2*DW +: DW] <= DW'(prod >>> (DW - 1));
    end
`else
    always_ff @(posedge clk) begin
        if (v1) shadow[k1*DW +: DW] <= s;
    end
`endif

endmodule
